// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar sweep controller: state encoding and frame length.
package sonar_pkg;

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARA        = 4'd1,
    MEDE           = 4'd2,
    AGUARDA_MEDIDA = 4'd3,
    TRANSMITE      = 4'd4,
    AGUARDA_TX     = 4'd5,
    ESPERA_TIMER   = 4'd6,
    PROX_POSICAO   = 4'd7,
    ERRO           = 4'd15
  } estado_t;

  localparam int         NUM_CHARS = 8;
  localparam logic [2:0] LAST_CHAR = 3'(NUM_CHARS - 1);

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with synchronous clear; fim flags the terminal count M-1.
module contador_m #(
  parameter int M = 100,
  parameter int N = 7
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera_s,
  input  logic         conta,
  output logic [N-1:0] q,
  output logic         fim
);

  localparam logic [N-1:0] ULTIMO = N'(M - 1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          q <= '0;
    else if (zera_s)     q <= '0;
    else if (conta) begin
      if (q == ULTIMO)   q <= '0;
      else               q <= q + 1'b1;
    end
  end

  assign fim = (q == ULTIMO);

endmodule

// File: rtl/sonar_uc.sv
// Sonar sweep control unit (Moore FSM): measure, send 8-char frame, wait, step servo.
// Optional measurement watchdog enabled by defining SONAR_UC_WATCHDOG_EN.
module sonar_uc
  import sonar_pkg::*;
#(
  parameter int TIMEOUT_MEDIDA = 1_500_000,
  parameter int TIMEOUT_W      = 21
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       pronto_medida,
  input  logic       pronto_serial,
  input  logic       fim_timer,
  output logic       zera_timer,
  output logic       conta_timer,
  output logic       zera_posicao,
  output logic       conta_posicao,
  output logic       reset_servo,
  output logic       medir,
  output logic       partida_serial,
  output logic [2:0] sel_letra,
  output logic       erro_medida,
  output logic [3:0] db_estado
);

  estado_t    estado;
  logic [2:0] indice;
  logic       wd_fim;

`ifdef SONAR_UC_WATCHDOG_EN
  logic [TIMEOUT_W-1:0] wd_q;

  // Cleared while in MEDE so the count starts at 0 on the first AGUARDA_MEDIDA cycle.
  contador_m #(.M(TIMEOUT_MEDIDA), .N(TIMEOUT_W)) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .zera_s (estado == MEDE),
    .conta  (estado == AGUARDA_MEDIDA),
    .q      (wd_q),
    .fim    (wd_fim)
  );
`else
  assign wd_fim = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= INICIAL;
      indice <= '0;
    end else begin
      case (estado)
        INICIAL:        if (ligar) estado <= PREPARA;
        PREPARA: begin
          indice <= '0;
          estado <= MEDE;
        end
        MEDE:           estado <= AGUARDA_MEDIDA;
        // A measurement landing on the timeout cycle still wins.
        AGUARDA_MEDIDA: begin
          if (pronto_medida) begin
            indice <= '0;
            estado <= TRANSMITE;
          end else if (wd_fim) begin
            estado <= ERRO;
          end
        end
        TRANSMITE:      estado <= AGUARDA_TX;
        AGUARDA_TX: begin
          if (pronto_serial) begin
            if (indice == LAST_CHAR) begin
              estado <= ESPERA_TIMER;
            end else begin
              indice <= indice + 1'b1;
              estado <= TRANSMITE;
            end
          end
        end
        ESPERA_TIMER:   if (fim_timer) estado <= PROX_POSICAO;
        PROX_POSICAO:   estado <= ligar ? MEDE : INICIAL;
        ERRO:           if (!ligar) estado <= INICIAL;
        default:        estado <= INICIAL;
      endcase
    end
  end

  always_comb begin
    zera_timer     = 1'b0;
    conta_timer    = 1'b0;
    zera_posicao   = 1'b0;
    conta_posicao  = 1'b0;
    reset_servo    = 1'b0;
    medir          = 1'b0;
    partida_serial = 1'b0;
    sel_letra      = 3'd0;
    erro_medida    = 1'b0;
    case (estado)
      PREPARA: begin
        zera_timer   = 1'b1;
        zera_posicao = 1'b1;
        reset_servo  = 1'b1;
      end
      MEDE:         medir = 1'b1;
      TRANSMITE: begin
        partida_serial = 1'b1;
        sel_letra      = indice;
      end
      AGUARDA_TX:   sel_letra = indice;
      ESPERA_TIMER: conta_timer = 1'b1;
      PROX_POSICAO: begin
        conta_posicao = 1'b1;
        zera_timer    = 1'b1;
      end
      ERRO: begin
        erro_medida = 1'b1;
        reset_servo = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_sonar_uc.sv
// Directed self-checking bench for sonar_uc with a short watchdog timeout.
module tb_sonar_uc;

  logic       clock = 1'b0;
  logic       reset;
  logic       ligar, pronto_medida, pronto_serial, fim_timer;
  logic       zera_timer, conta_timer, zera_posicao, conta_posicao;
  logic       reset_servo, medir, partida_serial, erro_medida;
  logic [2:0] sel_letra;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;
  int n_part = 0;

  sonar_uc #(.TIMEOUT_MEDIDA(20), .TIMEOUT_W(5)) dut (
    .clock          (clock),
    .reset          (reset),
    .ligar          (ligar),
    .pronto_medida  (pronto_medida),
    .pronto_serial  (pronto_serial),
    .fim_timer      (fim_timer),
    .zera_timer     (zera_timer),
    .conta_timer    (conta_timer),
    .zera_posicao   (zera_posicao),
    .conta_posicao  (conta_posicao),
    .reset_servo    (reset_servo),
    .medir          (medir),
    .partida_serial (partida_serial),
    .sel_letra      (sel_letra),
    .erro_medida    (erro_medida),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (partida_serial) n_part++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [11:0] outs();
    return {zera_timer, conta_timer, zera_posicao, conta_posicao, reset_servo,
            medir, partida_serial, erro_medida, 1'b0, sel_letra};
  endfunction

  // Starting in TRANSMITE with index 0: serve all 8 characters, ending in ESPERA_TIMER.
  task automatic run_frame(input int drop_at);
    int p0;
    p0 = n_part;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tx_state_%0d", i), db_estado, 4);
      chk($sformatf("tx_sel_%0d", i), {partida_serial, sel_letra}, {1'b1, 3'(i)});
      if (i == drop_at) ligar = 1'b0;
      tick();
      chk($sformatf("wait_sel_%0d", i), {db_estado, partida_serial, sel_letra}, {4'd5, 1'b0, 3'(i)});
      tick();
      tick();
      pronto_serial = 1'b1;
      tick();
      pronto_serial = 1'b0;
    end
    chk("frame_partidas", n_part - p0, 8);
    chk("frame_end", {db_estado, conta_timer}, {4'd6, 1'b1});
  endtask

  // From INICIAL with ligar=1 up to the first AGUARDA_MEDIDA cycle.
  task automatic start_to_wait();
    ligar = 1'b1;
    tick();
    chk("prepara", {db_estado, outs()}, {4'd1, 12'b1010_1000_0000});
    tick();
    chk("mede", {db_estado, medir}, {4'd2, 1'b1});
    tick();
    chk("aguarda", db_estado, 3);
  endtask

  initial begin
    reset = 1'b0; ligar = 1'b0; pronto_medida = 1'b0; pronto_serial = 1'b0; fim_timer = 1'b0;
    #12;
    chk("rst_state", db_estado, 0);
    chk("rst_outs", outs(), 0);
    @(negedge clock) reset = 1'b1;
    tick(); tick();
    chk("idle_ligar0", {db_estado, outs()}, 16'h0);

    // Full frame with measurement arriving after 5 cycles.
    start_to_wait();
    for (int k = 0; k < 4; k++) tick();
    chk("aguarda_hold", db_estado, 3);
    pronto_medida = 1'b1;
    tick();
    pronto_medida = 1'b0;
    run_frame(-1);

    // Stray pulses while waiting for the timer are ignored.
    pronto_serial = 1'b1; pronto_medida = 1'b1;
    tick();
    pronto_serial = 1'b0; pronto_medida = 1'b0;
    chk("stray_ignored", {db_estado, partida_serial}, {4'd6, 1'b0});
    tick();
    chk("stray_ignored2", {db_estado, conta_timer}, {4'd6, 1'b1});

    // Timer expiry advances the position and measures again.
    fim_timer = 1'b1;
    tick();
    fim_timer = 1'b0;
    chk("prox_pos", {db_estado, outs()}, {4'd7, 12'b1001_0000_0000});
    tick();
    chk("re_mede", {db_estado, medir}, {4'd2, 1'b1});
    tick();
    pronto_medida = 1'b1;
    tick();
    pronto_medida = 1'b0;

    // Sweep switched off mid-frame: frame completes, position still steps.
    run_frame(3);
    fim_timer = 1'b1;
    tick();
    fim_timer = 1'b0;
    chk("drop_prox_pos", {db_estado, conta_posicao}, {4'd7, 1'b1});
    tick();
    chk("drop_idle", {db_estado, outs()}, 16'h0);

    // Asynchronous reset in the middle of AGUARDA_TX.
    start_to_wait();
    pronto_medida = 1'b1;
    tick();
    pronto_medida = 1'b0;
    tick();
    chk("pre_rst_tx", db_estado, 5);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_state", db_estado, 0);
    chk("async_rst_outs", outs(), 0);
    ligar = 1'b0;
    @(negedge clock) reset = 1'b1;
    tick(); tick();
    chk("post_rst_idle", {db_estado, outs()}, 16'h0);

`ifdef SONAR_UC_WATCHDOG_EN
    // No measurement: 20 cycles in AGUARDA_MEDIDA, then ERRO.
    start_to_wait();
    for (int k = 0; k < 19; k++) tick();
    chk("wd_cycle20", db_estado, 3);
    tick();
    chk("wd_erro", {db_estado, erro_medida, reset_servo}, {4'd15, 1'b1, 1'b1});
    tick();
    chk("wd_erro_hold", db_estado, 15);
    ligar = 1'b0;
    tick();
    chk("wd_erro_exit", {db_estado, outs()}, 16'h0);
    // Measurement on the timeout cycle wins.
    start_to_wait();
    for (int k = 0; k < 19; k++) tick();
    pronto_medida = 1'b1;
    tick();
    pronto_medida = 1'b0;
    chk("wd_race", {db_estado, erro_medida}, {4'd4, 1'b0});
`else
    start_to_wait();
    for (int k = 0; k < 30; k++) tick();
    chk("no_wd_wait", {db_estado, erro_medida}, {4'd3, 1'b0});
    pronto_medida = 1'b1;
    tick();
    pronto_medida = 1'b0;
    chk("no_wd_tx", db_estado, 4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sonar_uc.md
SONAR_UC -- requirements
Module: sonar_uc

Interface
REQ-001 SHALL have parameter TIMEOUT_MEDIDA, default 1_500_000, clocks waited for pronto_medida before error (30 ms at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_W, default 21, width of the watchdog counter.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; all other ports are synchronous to clock.
REQ-004 clock  in  1  system clock, 50 MHz.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 ligar  in  1  level; high = run sonar sweep.
REQ-007 pronto_medida  in  1  pulse from sensor interface, measurement done.
REQ-008 pronto_serial  in  1  pulse from UART, character sent.
REQ-009 fim_timer  in  1  2 s inter-position timer expired.
REQ-010 zera_timer, conta_timer, zera_posicao, conta_posicao, reset_servo, medir, partida_serial  out  1 each  datapath controls.
REQ-011 sel_letra  out  3  character index into datapath mux.
REQ-012 erro_medida  out  1  measurement watchdog fired.
REQ-013 db_estado  out  4  current state code.

Function
REQ-014 SHALL be a Moore FSM; every output decoded from the state register and the character index only.
REQ-015 States/codes: INICIAL 0, PREPARA 1, MEDE 2, AGUARDA_MEDIDA 3, TRANSMITE 4, AGUARDA_TX 5, ESPERA_TIMER 6, PROX_POSICAO 7, ERRO 15.
REQ-016 INICIAL: all outputs 0; ligar=1 -> PREPARA.
REQ-017 PREPARA (1 cycle): zera_timer=zera_posicao=reset_servo=1; clear character index; -> MEDE.
REQ-018 MEDE (1 cycle): medir=1; -> AGUARDA_MEDIDA.
REQ-019 AGUARDA_MEDIDA: wait; pronto_medida=1 -> TRANSMITE with index 0.
REQ-020 TRANSMITE (1 cycle): partida_serial=1, sel_letra=index; -> AGUARDA_TX.
REQ-021 AGUARDA_TX: sel_letra=index held; on pronto_serial, index<7 -> index+1, TRANSMITE; index=7 -> ESPERA_TIMER.
REQ-022 Frame order SHALL be index 0..7: angle hundreds, tens, units, ',', distance hundreds, tens, units, '#'.
REQ-023 ESPERA_TIMER: conta_timer=1; fim_timer=1 -> PROX_POSICAO.
REQ-024 PROX_POSICAO (1 cycle): conta_posicao=1, zera_timer=1; ligar=1 -> MEDE, ligar=0 -> INICIAL.
REQ-025 ligar falling mid-frame SHALL NOT abort; sweep stops only at PROX_POSICAO (position already advanced).
REQ-026 pronto_* pulses arriving in states other than their wait state SHALL be ignored.
REQ-027 Index SHALL never exceed 7; no wrap-around while transmitting.
REQ-028 ERRO: erro_medida=1, reset_servo=1; ligar=0 -> INICIAL; otherwise stay.

Reset
REQ-029 reset=0 SHALL immediately force INICIAL, index 0, watchdog 0, all outputs 0, db_estado 0, including mid-frame.
REQ-030 After reset release, first transition SHALL be on the first rising edge with ligar=1.

Configuration
REQ-031 Macro SONAR_UC_WATCHDOG_EN defined: counter clears on entry to AGUARDA_MEDIDA, counts each cycle there; reaching TIMEOUT_MEDIDA-1 without pronto_medida -> ERRO.
REQ-032 Same-cycle pronto_medida and timeout SHALL go to TRANSMITE.
REQ-033 Macro undefined: no counter logic, erro_medida tied 0, ERRO unreachable, AGUARDA_MEDIDA waits indefinitely.

Structure
REQ-034 Package sonar_pkg SHALL hold the state encoding type (4-bit), NUM_CHARS=8 and LAST_CHAR=3'd7.
REQ-035 Watchdog SHALL reuse existing contador_m (M=TIMEOUT_MEDIDA, N=TIMEOUT_W); no other sub-module.

Verification (TIMEOUT_MEDIDA=20 in bench)
REQ-036 Reset low mid-AGUARDA_TX -> db_estado=0, all outputs 0 same cycle, stays 0 after release with ligar=0.
REQ-037 ligar=1, pronto_medida after 5 cycles, each pronto_serial 3 cycles after partida -> exactly 8 partida_serial pulses, sel_letra 0..7 in order, then conta_timer=1.
REQ-038 fim_timer pulse with ligar=1 -> one conta_posicao pulse coincident with zera_timer, then medir pulse next cycle.
REQ-039 ligar dropped during index 3 -> frame finishes to index 7, one conta_posicao, then db_estado=0.
REQ-040 WATCHDOG_EN, no pronto_medida -> db_estado=15 and erro_medida=1 after 20 cycles in state 3; pronto_medida on cycle 20 -> state 4 instead.
REQ-041 Stray pronto_serial in ESPERA_TIMER -> no state change, no partida_serial.
